// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller.
//   tlc_state_t     : FSM state encoding S0..S3
//   LFSR_LOCKUP_SUB : seed substituted for an all-zero LFSR seed
//   tlc_lamps_t     : one road's red/green/yellow lamp triple
//   tlc_decode()    : state -> lamps for both roads
package tlc_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,   // A green,  B red
        S1 = 2'd1,   // A yellow, B red
        S2 = 2'd2,   // A red,    B green
        S3 = 2'd3    // A red,    B yellow
    } tlc_state_t;

    localparam logic [3:0] LFSR_LOCKUP_SUB = 4'b0001;

    typedef struct packed {
        logic r;
        logic g;
        logic y;
    } tlc_lamps_t;

    typedef struct packed {
        tlc_lamps_t a;
        tlc_lamps_t b;
    } tlc_out_t;

    // Exactly one lamp per road in every state, never both greens.
    function automatic tlc_out_t tlc_decode(input tlc_state_t s);
        tlc_out_t o;
        case (s)
            S0:      begin o.a = '{r:1'b0, g:1'b1, y:1'b0}; o.b = '{r:1'b1, g:1'b0, y:1'b0}; end
            S1:      begin o.a = '{r:1'b0, g:1'b0, y:1'b1}; o.b = '{r:1'b1, g:1'b0, y:1'b0}; end
            S2:      begin o.a = '{r:1'b1, g:1'b0, y:1'b0}; o.b = '{r:1'b0, g:1'b1, y:1'b0}; end
            default: begin o.a = '{r:1'b1, g:1'b0, y:1'b0}; o.b = '{r:1'b0, g:1'b0, y:1'b1}; end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/traffic_sensor.sv
// Pseudo-random traffic sensor: 4-bit LFSR, presence flag is the MSB.
//   clk : clock, rising edge
//   rst : synchronous active-low reset, reloads SEED
//   T   : traffic present
module traffic_sensor
    import tlc_pkg::*;
#(
    parameter logic [3:0] SEED = 4'b0001
)(
    input  logic clk,
    input  logic rst,
    output logic T
);

    // An all-zero LFSR would never leave zero.
    localparam logic [3:0] SEED_EFF = (SEED == 4'b0000) ? LFSR_LOCKUP_SUB : SEED;

    logic [3:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) lfsr <= SEED_EFF;
        else      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign T = lfsr[3];

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road traffic light controller driven by two LFSR traffic sensors.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset (state S0, sensors reseeded)
//   Ra/Ga/Ya   : road-A red/green/yellow lamps
//   Rb/Gb/Yb   : road-B red/green/yellow lamps
//   Ta/Tb      : sensor values, only when TLC_SENSOR_PORTS_EN is defined
// Parameters: SEED_A, SEED_B sensor seeds; YELLOW_CYCLES yellow length (1..15).
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter logic [3:0]  SEED_A        = 4'b1001,
    parameter logic [3:0]  SEED_B        = 4'b0110,
    parameter int unsigned YELLOW_CYCLES = 1
)(
    input  logic clk,
    input  logic rst,
    output logic Ra,
    output logic Ga,
    output logic Ya,
    output logic Rb,
    output logic Gb,
    output logic Yb
`ifdef TLC_SENSOR_PORTS_EN
    ,
    output logic Ta,
    output logic Tb
`endif
);

    localparam logic [3:0] YEL_LAST = 4'(YELLOW_CYCLES - 1);

    logic       ta, tb;
    tlc_state_t state, state_n;
    logic [3:0] ycnt, ycnt_n;
    tlc_out_t   lamps;

    traffic_sensor #(.SEED(SEED_A)) u_sensor_a (.clk(clk), .rst(rst), .T(ta));
    traffic_sensor #(.SEED(SEED_B)) u_sensor_b (.clk(clk), .rst(rst), .T(tb));

`ifdef TLC_SENSOR_PORTS_EN
    assign Ta = ta;
    assign Tb = tb;
`endif

    // Yellow counter is cleared on entry to a yellow state and counts the
    // cycles spent there; leaving happens on its last cycle.
    always_comb begin
        state_n = S0;
        ycnt_n  = ycnt;
        case (state)
            S0: begin
                if (ta) state_n = S0;
                else begin state_n = S1; ycnt_n = 4'd0; end
            end
            S1: begin
                if (ycnt == YEL_LAST) state_n = S2;
                else begin state_n = S1; ycnt_n = ycnt + 4'd1; end
            end
            S2: begin
                if (tb) state_n = S2;
                else begin state_n = S3; ycnt_n = 4'd0; end
            end
            S3: begin
                if (ycnt == YEL_LAST) state_n = S0;
                else begin state_n = S3; ycnt_n = ycnt + 4'd1; end
            end
            default: begin state_n = S0; ycnt_n = 4'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S0;
            ycnt  <= 4'd0;
        end else begin
            state <= state_n;
            ycnt  <= ycnt_n;
        end
    end

    // Moore outputs: a pure decode of the state register.
    assign lamps = tlc_decode(state);
    assign Ra = lamps.a.r;
    assign Ga = lamps.a.g;
    assign Ya = lamps.a.y;
    assign Rb = lamps.b.r;
    assign Gb = lamps.b.g;
    assign Yb = lamps.b.y;

endmodule

// File: tb/tb_traffic_light_controller.sv
`timescale 1ns/1ps
module tb_traffic_light_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Ra, Ga, Ya, Rb, Gb, Yb;
    logic Ra3, Ga3, Ya3, Rb3, Gb3, Yb3;
`ifdef TLC_SENSOR_PORTS_EN
    logic Ta, Tb, Ta3, Tb3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk(clk), .rst(rst),
        .Ra(Ra), .Ga(Ga), .Ya(Ya), .Rb(Rb), .Gb(Gb), .Yb(Yb)
`ifdef TLC_SENSOR_PORTS_EN
        , .Ta(Ta), .Tb(Tb)
`endif
    );

    traffic_light_controller #(.YELLOW_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .Ra(Ra3), .Ga(Ga3), .Ya(Ya3), .Rb(Rb3), .Gb(Gb3), .Yb(Yb3)
`ifdef TLC_SENSOR_PORTS_EN
        , .Ta(Ta3), .Tb(Tb3)
`endif
    );

    // Reference model: phase 0..3 = A green, A yellow, B green, B yellow;
    // yr = yellow cycles still to serve. Both DUTs share seeds and reset,
    // so one pair of sensor registers serves both.
    int         ph1, yr1, ph3, yr3;
    logic [3:0] la, lb;

    // Lamp vector {Ra,Ga,Ya,Rb,Gb,Yb} for a phase.
    function automatic logic [5:0] exp_lamps(input int ph);
        case (ph)
            0:       return 6'b010_100;
            1:       return 6'b001_100;
            2:       return 6'b100_010;
            default: return 6'b100_001;
        endcase
    endfunction

    task automatic step_phase(inout int ph, inout int yr, input int yc, input bit ta, input bit tb);
        case (ph)
            0: if (!ta) begin ph = 1; yr = yc; end
            1: begin yr = yr - 1; if (yr == 0) ph = 2; end
            2: if (!tb) begin ph = 3; yr = yc; end
            default: begin yr = yr - 1; if (yr == 0) ph = 0; end
        endcase
    endtask

    task automatic model_edge();
        if (!rst) begin
            ph1 = 0; yr1 = 0; ph3 = 0; yr3 = 0;
            la = 4'b1001; lb = 4'b0110;
        end else begin
            step_phase(ph1, yr1, 1, la[3], lb[3]);
            step_phase(ph3, yr3, 3, la[3], lb[3]);
            la = {la[2:0], la[3] ^ la[2]};
            lb = {lb[2:0], lb[3] ^ lb[2]};
        end
    endtask

    // One clock: model follows the edge, return on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b0;
        tick();
        tick();
        got = {Ra, Ga, Ya, Rb, Gb, Yb};
        checks++;
        if (got !== 6'b010_100) begin
            failures++;
            $display("FAIL reset_during: got %b expected %b", got, 6'b010_100);
        end
        rst = 1'b1;
        #1;
        got = {Ra, Ga, Ya, Rb, Gb, Yb};
        checks++;
        if (got !== 6'b010_100) begin
            failures++;
            $display("FAIL reset_after: got %b expected %b", got, 6'b010_100);
        end
        got = {Ra3, Ga3, Ya3, Rb3, Gb3, Yb3};
        checks++;
        if (got !== 6'b010_100) begin
            failures++;
            $display("FAIL reset_after_y3: got %b expected %b", got, 6'b010_100);
        end
    endtask

    task automatic test_default_sequence();
        logic [5:0] seqv [5];
        logic [5:0] got;
        seqv = '{6'b010_100, 6'b001_100, 6'b100_010, 6'b100_001, 6'b010_100};
        do_reset();
        for (int e = 0; e < 5; e++) begin
            tick();
            got = {Ra, Ga, Ya, Rb, Gb, Yb};
            checks++;
            if (got !== seqv[e]) begin
                failures++;
                $display("FAIL default_seq edge%0d: got %b expected %b", e + 1, got, seqv[e]);
            end
        end
    endtask

    task automatic test_sensor_ports();
`ifdef TLC_SENSOR_PORTS_EN
        logic [5:0] exp_ta, exp_tb;
        exp_ta = 6'b100110;   // first value in the MSB
        exp_tb = 6'b011010;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if ({Ta, Tb} !== {exp_ta[5-i], exp_tb[5-i]}) begin
                failures++;
                $display("FAIL sensor_seq value%0d: got Ta=%b Tb=%b expected Ta=%b Tb=%b",
                         i, Ta, Tb, exp_ta[5-i], exp_tb[5-i]);
            end
        end
`endif
    endtask

    task automatic test_yellow3();
        int guard;
        int n;
        do_reset();
        guard = 0;
        while (!Ya3 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (!Ya3) begin
            failures++;
            $display("FAIL yellow3_start: got Ya=%b expected 1 within 20 cycles", Ya3);
        end
        n = 0;
        while (Ya3 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL yellow3_len: got %0d cycles expected 3", n);
        end
        checks++;
        if ({Ra3, Gb3} !== 2'b11) begin
            failures++;
            $display("FAIL yellow3_next: got Ra=%b Gb=%b expected Ra=1 Gb=1", Ra3, Gb3);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        do_reset();
        tick(); tick(); tick();
        got = {Ra, Ga, Ya, Rb, Gb, Yb};
        checks++;
        if (got !== 6'b100_010) begin
            failures++;
            $display("FAIL mid_reset_in_s2: got %b expected %b", got, 6'b100_010);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {Ra, Ga, Ya, Rb, Gb, Yb};
            checks++;
            if (got !== 6'b010_100) begin
                failures++;
                $display("FAIL mid_reset_hold%0d: got %b expected %b", i, got, 6'b010_100);
            end
        end
        rst = 1'b1;
        #1;
`ifdef TLC_SENSOR_PORTS_EN
        checks++;
        if ({Ta, Tb} !== 2'b10) begin
            failures++;
            $display("FAIL mid_reset_seed: got Ta=%b Tb=%b expected Ta=1 Tb=0", Ta, Tb);
        end
`endif
        // Reseeded sensors replay the default opening: stay, then yellow.
        tick();
        got = {Ra, Ga, Ya, Rb, Gb, Yb};
        checks++;
        if (got !== 6'b010_100) begin
            failures++;
            $display("FAIL mid_reset_edge1: got %b expected %b", got, 6'b010_100);
        end
        tick();
        got = {Ra, Ga, Ya, Rb, Gb, Yb};
        checks++;
        if (got !== 6'b001_100) begin
            failures++;
            $display("FAIL mid_reset_edge2: got %b expected %b", got, 6'b001_100);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, got3;
        for (int c = 0; c < 1000; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            tick();
            got  = {Ra, Ga, Ya, Rb, Gb, Yb};
            got3 = {Ra3, Ga3, Ya3, Rb3, Gb3, Yb3};
            checks++;
            if (got !== exp_lamps(ph1)) begin
                failures++;
                $display("FAIL random_y1 cycle%0d: got %b expected %b", c, got, exp_lamps(ph1));
            end
            checks++;
            if (got3 !== exp_lamps(ph3)) begin
                failures++;
                $display("FAIL random_y3 cycle%0d: got %b expected %b", c, got3, exp_lamps(ph3));
            end
            checks++;
            if (!($onehot({Ra, Ga, Ya}) && $onehot({Rb, Gb, Yb}) && !(Ga && Gb) &&
                  $onehot({Ra3, Ga3, Ya3}) && $onehot({Rb3, Gb3, Yb3}) && !(Ga3 && Gb3))) begin
                failures++;
                $display("FAIL random_lamp_rule cycle%0d: got %b / %b expected one lamp per road, no double green",
                         c, got, got3);
            end
`ifdef TLC_SENSOR_PORTS_EN
            checks++;
            if ({Ta, Tb, Ta3, Tb3} !== {la[3], lb[3], la[3], lb[3]}) begin
                failures++;
                $display("FAIL random_sensors cycle%0d: got %b expected %b",
                         c, {Ta, Tb, Ta3, Tb3}, {la[3], lb[3], la[3], lb[3]});
            end
`endif
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_default_sequence();
        test_sensor_ports();
        test_yellow3();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
